load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage between the core MEM stage and the word-wide data RAM
//  (async read, sync write on posedge clock). Accepts byte/half/word loads and stores
//  on a valid/ready handshake, aligns and sign-extends load data, and performs
//  read-modify-write for sub-word stores since the RAM only writes full words.
// PARAMETERS
//  MEM_DEPTH  1024  words in data RAM
//  SIZE       32    data width; only 32 supported
//  ADDR_W     $clog2(MEM_DEPTH-1)  RAM word-address width (localparam, matches RAM port)
// PORTS
//  clock         in   1       single clock, all state on posedge
//  reset         in   1       synchronous, active-high
//  req_valid     in   1       request present
//  req_ready     out  1       unit idle, request accepted when valid&&ready
//  req_we        in   1       1=store, 0=load
//  req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1       loads: 1=zero-extend, 0=sign-extend
//  req_addr      in   32      byte address
//  req_wdata     in   SIZE    store data, right-justified
//  resp_valid    out  1       one-cycle completion pulse
//  resp_rdata    out  SIZE    load result (0 for stores/errors)
//  resp_err      out  1       valid with resp_valid; request rejected
//  ram_address   out  ADDR_W  = latched req_addr[ADDR_W+1:2]
//  ram_data_in   out  SIZE    word to write
//  ram_wren      out  1       RAM write enable
//  ram_data_out  in   SIZE    RAM async read data
// BEHAVIOUR
//  - Reset: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched request=0.
//    ram_wren = (state==WRITE) && !reset: write in flight at reset edge is suppressed.
//  - req_ready=1 only in IDLE. Request fields latched on acceptance edge; inputs may change after.
//  - FSM: IDLE -> LOAD (load) | WRITE (word store) | RMW_RD (byte/half store) | ERR (error).
//    LOAD: capture ram_data_out, extract lane, extend -> resp_rdata; -> IDLE, resp_valid=1.
//    RMW_RD: merge reg = ram_data_out with new lane(s) replaced; -> WRITE.
//    WRITE: ram_wren=1, ram_data_in = req word or merge reg; -> IDLE, resp_valid=1.
//    ERR: no RAM access; -> IDLE, resp_valid=1, resp_err=1, resp_rdata=0.
//  - Latency acceptance edge -> resp_valid high: load 1 cycle, word store 1, sub-word store 2,
//    error 1. resp_valid coincides with IDLE, so back-to-back requests run at full rate.
//  - Lanes: byte = addr[1:0]*8; half = addr[1]*16. Sign bit = top bit of extracted lane.
//  - Sub-word store writes req_wdata[7:0] / [15:0] into lane; other bytes preserved.
//  - req_size==11 always -> ERR.
//  - Address bits above ADDR_W+1 ignored: accesses wrap modulo MEM_DEPTH words.
//  - resp_valid/resp_err/resp_rdata registered; resp_rdata holds until next response.
//  - Reset mid-operation: FSM to IDLE, response dropped, no partial write.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 -> ERR,
//    RAM untouched.
//  Not defined: misaligned low bits forced to alignment (half clears addr[0], word
//    clears addr[1:0]) and access proceeds normally; resp_err only for size 11.
// TESTING
//  1 reset; store word 0xDEADBEEF @0x10; load word @0x10 -> resp_rdata=0xDEADBEEF,
//    resp_valid 1 cycle after each acceptance, resp_err=0.
//  2 store byte 0xA5 @0x11 -> RAM word 4 = 0xDEADA5EF, ram_wren high exactly 1 cycle;
//    load byte signed @0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
//  3 store half 0x1234 @0x12 -> word 0x1234A5EF; load half signed @0x12 -> 0x00001234;
//    load half signed @0x10 -> 0xFFFFA5EF.
//  4 load word @0x13: with LSU_MISALIGN_TRAP_EN -> resp_err=1, rdata=0, no RAM write;
//    without -> rdata=0x1234A5EF. req_size=11 -> resp_err=1 in both builds.
//  5 byte store in progress, reset high during WRITE cycle -> ram_wren=0 at that edge,
//    memory unchanged, no resp_valid, req_ready=1 cycle after reset drops.
//  6 store word 0x0000CAFE @ byte addr 4*MEM_DEPTH+8 -> load word @0x8 returns 0x0000CAFE;
//    req_valid held during busy states -> accepted only when req_ready=1, no lost requests.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory access stage: byte/half/word loads and stores against a word-wide RAM,
// with sign/zero extension of loads and read-modify-write for sub-word stores.
// Latency: acceptance edge to resp_valid is 1 cycle for loads, word stores and errors, 2 for sub-word stores.
// Backpressure: req_ready is high only in IDLE, and a request is taken on req_valid && req_ready.
//
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with
// resp_err. When it is undefined, the misaligned low address bits are cleared and the access proceeds.
//
// Ports:
//   clock, reset               single clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_we                     request field: store when 1, load when 0
//   req_size                   request field: 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned               request field: loads zero-extend when 1, sign-extend when 0
//   req_addr                   request field: byte address
//   req_wdata                  request field: store data, right-justified
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       load result and error flag; registered, held until the next response
//   ram_address, ram_data_in   word-RAM write port
//   ram_wren                   word-RAM write enable
//   ram_data_out               asynchronous read data from the word RAM
module load_store_unit #(
  parameter int  MEM_DEPTH = 1024,
  parameter int  SIZE      = 32,
  localparam int ADDR_W    = $clog2(MEM_DEPTH-1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [SIZE-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [SIZE-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [SIZE-1:0]   ram_data_in,
  output logic              ram_wren,
  input  logic [SIZE-1:0]   ram_data_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W+1:0] addr_q;
  logic [SIZE-1:0]   wdata_q;
  logic [SIZE-1:0]   merge_q, merge_d;
  logic [SIZE-1:0]   ld_value;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [ADDR_W+1:0] addr_aligned;
  logic              accept;
  logic              misaligned;
  logic              req_bad;
  logic              unused_addr_bits;

  // Address bits above the RAM range are dropped, so accesses wrap modulo MEM_DEPTH words.
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_bad = (req_size == 2'b11) || misaligned;

  // Clear the low bits that the access size does not use. In the trapping build,
  // misaligned requests go to ERR, so this clearing only matters in the non-trapping build.
  always_comb begin
    addr_aligned = req_addr[ADDR_W+1:0];
    if (req_size == 2'b01) begin
      addr_aligned[0] = 1'b0;
    end else if (req_size == 2'b10) begin
      addr_aligned[1:0] = 2'b00;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)                 state_d = ERR;
          else if (!req_we)            state_d = LOAD;
          else if (req_size == 2'b10)  state_d = WRITE;
          else                         state_d = RMW_RD;
        end
      end
      RMW_RD:          state_d = WRITE;
      LOAD, WRITE, ERR: state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  // Select the load lane and extend it; the sign source is the top bit of the selected lane.
  always_comb begin
    ld_byte = ram_data_out[{addr_q[1:0], 3'b000} +: 8];
    ld_half = ram_data_out[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_value = {{(SIZE-8){ld_byte[7] & ~uns_q}}, ld_byte};
      2'b01:   ld_value = {{(SIZE-16){ld_half[15] & ~uns_q}}, ld_half};
      default: ld_value = ram_data_out;
    endcase
  end

  // Sub-word store: keep the current RAM word and replace only the addressed lane.
  always_comb begin
    merge_d = ram_data_out;
    if (size_q == 2'b00) begin
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_valid <= 1'b0;
      if (accept) begin
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= addr_aligned;
        wdata_q <= req_wdata;
      end
      case (state_q)
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= ld_value;
          resp_err   <= 1'b0;
        end
        RMW_RD: merge_q <= merge_d;
        WRITE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  // Gating the enable with reset means a write that is in flight at a reset edge never reaches the RAM.
  assign ram_wren    = (state_q == WRITE) && !reset;
  assign ram_address = addr_q[ADDR_W+1:2];
  assign ram_data_in = (size_q == 2'b10) ? wdata_q : merge_q;

endmodule
